// File: rtl/mil_tx_multi.sv
// MIL-STD-1553 word transmitter: show-ahead word FIFO feeding a Manchester-II
// encoder that drives one of CHANNELS redundant buses, with an enforced inter-message gap.
module mil_tx_multi #(
  parameter int CHANNELS      = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int HALF_BIT_CLKS = 50,
  parameter int GAP_HALF_BITS = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                tx_type,
  input  logic [15:0]         tx_word,
  input  logic [CW-1:0]       chan_sel,
  input  logic                abort,
  input  logic                clr_ovf,
  output logic [CHANNELS-1:0] line_p,
  output logic [CHANNELS-1:0] line_n,
  output logic [CHANNELS-1:0] tx_en,
  output logic                busy,
  output logic                word_done,
  output logic                overflow,
  output logic [LW-1:0]       fifo_level
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int HW       = $clog2(HALF_BIT_CLKS);
  localparam int GAP_CLKS = GAP_HALF_BITS * HALF_BIT_CLKS;
  localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [HW-1:0] HB_LAST  = HW'(HALF_BIT_CLKS - 1);
  localparam logic [HW-1:0] HB_PRE   = HW'(HALF_BIT_CLKS - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [5:0]    LAST_HB  = 6'd39;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  // Full 40-half-bit frame, half-bit 0 in the MSB so the frame shifts out left.
  function automatic logic [39:0] encode(input logic typ, input logic [15:0] w);
    logic [39:0] f;
    f        = '0;
    f[39:34] = typ ? 6'b111000 : 6'b000111;
    for (int k = 0; k < 16; k++) begin
      f[33-2*k -: 2] = {w[15-k], ~w[15-k]};
    end
    f[1:0] = {~^w, ^w};
    return f;
  endfunction

  // ---------------- word FIFO ----------------
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push, pop, fifo_empty;
  logic [16:0]   head;
  logic [39:0]   head_frame;

  assign tx_ready   = (count != FULL);
  assign fifo_level = count;
  assign fifo_empty = (count == '0);
  assign push       = tx_valid && tx_ready && !abort;
  assign head       = mem[rd_ptr];
  assign head_frame = encode(head[16], head[15:0]);

  // NOTE: storage has no reset; stale entries are unreachable because pointers and count reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tx_type, tx_word};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                         overflow <= 1'b0;
    else if (tx_valid && !tx_ready)  overflow <= 1'b1;
    else if (clr_ovf)                overflow <= 1'b0;
  end

  // ---------------- transmit FSM ----------------
  state_t        state, nxt_state;
  logic [39:0]   frame;
  logic [5:0]    half_idx;
  logic [HW-1:0] hb_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] chan, chan_nxt;
  logic          start_word, hb_end, word_end;
  logic          active_nxt, level_nxt;

  assign hb_end   = (hb_cnt == HB_LAST);
  assign word_end = hb_end && (half_idx == LAST_HB);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    nxt_state  = state;
    pop        = 1'b0;
    start_word = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) nxt_state = S_LOAD;
      S_LOAD: begin
        pop        = 1'b1;
        start_word = 1'b1;
        nxt_state  = S_SEND;
      end
      S_SEND: begin
        if (word_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            start_word = 1'b1;
          end else begin
            nxt_state = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP:   if (gap_cnt == GAP_LAST) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    if (abort) begin
      pop        = 1'b0;
      start_word = 1'b0;
      if (state == S_LOAD || state == S_SEND)
        nxt_state = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
      else if (state == S_IDLE)
        nxt_state = S_IDLE;
    end

    active_nxt = (nxt_state == S_SEND);
    level_nxt  = start_word ? head_frame[39] : (hb_end ? frame[38] : frame[39]);
    chan_nxt   = (state == S_LOAD) ? chan_sel : chan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      frame     <= '0;
      half_idx  <= '0;
      hb_cnt    <= '0;
      gap_cnt   <= '0;
      chan      <= '0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      line_p    <= '0;
      line_n    <= '0;
      tx_en     <= '0;
    end else begin
      state <= nxt_state;
      busy  <= (nxt_state != S_IDLE);
      // Registered one cycle early so the pulse lines up with the last cycle of half-bit 39.
      word_done <= (state == S_SEND) && (half_idx == LAST_HB) && (hb_cnt == HB_PRE) && !abort;

      if (state == S_LOAD) chan <= chan_sel;

      if (start_word) begin
        frame    <= head_frame;
        half_idx <= '0;
        hb_cnt   <= '0;
      end else if (state == S_SEND) begin
        if (hb_end) begin
          hb_cnt   <= '0;
          half_idx <= half_idx + 6'd1;
          frame    <= {frame[38:0], 1'b0};
        end else begin
          hb_cnt <= hb_cnt + HW'(1);
        end
      end

      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;

      for (int c = 0; c < CHANNELS; c++) begin
        tx_en[c]  <= active_nxt && (chan_nxt == CW'(c));
        line_p[c] <= active_nxt && (chan_nxt == CW'(c)) && level_nxt;
        line_n[c] <= active_nxt && (chan_nxt == CW'(c)) && !level_nxt;
      end
    end
  end

endmodule

// File: doc/mil_tx_multi.md
# mil_tx_multi

Parametrised MIL-STD-1553 word transmitter for the MIL/SPI bridge. It generalises the transmit half of the existing transceiver. The single-bus, single-word path becomes N redundant bus channels with a show-ahead word FIFO, a configurable bit rate and an enforced inter-message gap. Words arrive on a valid/ready push (type + 16-bit word) and leave as Manchester-II encoded differential line drive on the selected channel. Consecutive queued words go out contiguously, forming one 1553 message.

## Interface
- CHANNELS, 2, number of redundant bus outputs (≥1)
- FIFO_DEPTH, 4, word FIFO depth (≥2, power of two)
- HALF_BIT_CLKS, 50, clk cycles per Manchester half-bit (≥2; 50 → 1 Mbit/s at 100 MHz)
- GAP_HALF_BITS, 4, minimum idle half-bits between messages (0 allowed)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  push request
- tx_ready  out  1  FIFO not full
- tx_type  in  1  1 = command/status sync (WSERV), 0 = data sync (WDATA)
- tx_word  in  16  word payload, MSB sent first
- chan_sel  in  $clog2(CHANNELS) (min 1)  channel for next message
- abort  in  1  flush FIFO and stop driving
- clr_ovf  in  1  clears overflow
- line_p  out  CHANNELS  positive line drive
- line_n  out  CHANNELS  negative line drive
- tx_en  out  CHANNELS  driver enable
- busy  out  1  state ≠ IDLE
- word_done  out  1  one-cycle pulse at end of each word
- overflow  out  1  sticky, push attempted while full
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words queued

## Operation
- Word frame: 40 half-bits, indices 0..39.
  - Sync, half-bits 0–5: command 1,1,1,0,0,0; data 0,0,0,1,1,1.
  - Data bit k, half-bits 6+2k and 7+2k: a 1 is sent as 1,0 and a 0 as 0,1.
  - Parity, half-bits 38–39: parity bit = ~^word (odd parity), Manchester-coded like a data bit.
- Active channel c: line_p[c] = level, line_n[c] = ~level, tx_en[c] = 1.
- All other channels, and all channels when not sending: line_p = line_n = tx_en = 0.
- FIFO is show-ahead. Push accepted when tx_valid && tx_ready. A push with tx_valid && !tx_ready is dropped and sets overflow.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but tx_ready is still low that cycle, so the push is dropped.
  - If clr_ovf and an overflowing push occur in the same cycle, overflow stays set.
- States:
  - IDLE: outputs idle. FIFO non-empty → LOAD.
  - LOAD: latch chan_sel as the message channel; pop the head into the shift register → SEND.
  - SEND: drive half-bit sequence. At the last cycle of half-bit 39, pulse word_done.
    - FIFO non-empty: pop the head and start its half-bit 0 on the next cycle, same channel, no gap.
    - Otherwise go to GAP, or to IDLE if GAP_HALF_BITS = 0.
  - GAP: outputs idle for GAP_HALF_BITS×HALF_BIT_CLKS cycles → IDLE. Pushes are accepted during GAP.
- chan_sel is sampled only in LOAD; changes mid-message are ignored.
- abort (any state): next cycle FIFO empty, outputs idle.
  - From SEND, go to GAP. From LOAD, go to GAP. From IDLE or GAP, stay.
  - No word_done pulse for an aborted word. A push in the same cycle as abort is discarded.
- rst: FIFO empty; overflow, word_done, busy and all line outputs 0; state IDLE. tx_ready = 1. No gap is enforced after reset.

## Timing
- Latency: a push accepted at edge E in IDLE (FIFO was empty) → LOAD after E+1 → first sync half-bit on the outputs after E+2.
- Each half-bit lasts exactly HALF_BIT_CLKS cycles, so a word lasts 40×HALF_BIT_CLKS cycles (2000 at the default).
- Back-to-back words: zero idle cycles between half-bit 39 of word n and half-bit 0 of word n+1.
- Message end: first idle cycle immediately follows half-bit 39. The next LOAD occurs no earlier than GAP_HALF_BITS×HALF_BIT_CLKS cycles later.
- word_done is coincident with the last cycle of half-bit 39.
- fifo_level, tx_ready and overflow update on the edge of the push or pop.
- All outputs are registered; there are no combinational paths from inputs to line_p, line_n or tx_en.

## Test plan
- Single command word: defaults, chan_sel=0, push WSERV 16'h1111 (odd-parity bit = 1 because the word has four 1s).
  - line_p[0] shows 1,1,1,0,0,0, then bit pairs 0,1 ×3 then 1,0 per nibble, then parity 1,0.
  - First edge at push+2 cycles; word_done at +2000 cycles; channel 1 stays all-zero.
- Back-to-back message: push WSERV 16'h1111 then WDATA 16'h2222 on consecutive cycles.
  - Data sync 0,0,0,1,1,1 starts the cycle after word 1 ends; word_done at 2000 and 4000 cycles after first drive.
  - Then 200 idle cycles (GAP) before busy drops.
- Channel select: chan_sel=1, push WSERV 16'hAAAA, toggle chan_sel to 0 mid-word.
  - Only line_p[1]/line_n[1]/tx_en[1] toggle for the whole word; line_n[1] = ~line_p[1] throughout.
- Overflow: during SEND of one word, push 5 more.
  - 4 accepted, fifo_level=4, tx_ready=0, 5th sets overflow; clr_ovf clears it; all 4 words are sent contiguously.
- Abort: abort at half-bit 10 of the first of three queued words.
  - Lines idle next cycle, fifo_level=0, no word_done.
  - A word pushed immediately after abort starts only after 200 idle cycles.
- Reset mid-word: rst at half-bit 20.
  - All outputs 0 next cycle, FIFO empty.
  - A push right after release drives its first half-bit at push+2, with no gap.
